// File: rtl/mem_bus_arbiter.sv
// Shares the main-memory port between the I-cache and D-cache controllers.
// Each grant owns the port until its burst or write completes, then a one-cycle gap follows.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_rvalid,
  output logic [1:0]        i_word,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_rvalid,
  output logic [1:0]        d_word,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0]        LAST_BEAT = 2'(BURST - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    I_BURST,
    D_BURST,
    D_WRITE,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_side_q, last_side_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_i, grant_d;

  // last_side: 0 = I was granted most recently, 1 = D
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_side_d = last_side_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    i_rvalid    = 1'b0;
    i_word      = 2'd0;
    i_done      = 1'b0;
    d_rvalid    = 1'b0;
    d_word      = 2'd0;
    d_done      = 1'b0;
    rdata       = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        grant_i = i_req && (!d_req || last_side_q);
        grant_d = d_req && (!i_req || !last_side_q);
        cnt_d   = 2'd0;
        if (grant_i) begin
          state_d     = I_BURST;
          last_side_d = 1'b0;
          addr_d      = i_addr;
        end else if (grant_d) begin
          state_d     = d_we ? D_WRITE : D_BURST;
          last_side_d = 1'b1;
          addr_d      = d_addr;
          we_d        = d_we;
          wdata_d     = d_wdata;
        end
      end

      I_BURST, D_BURST: begin
        mem_req  = 1'b1;
        mem_addr = (addr_q & LINE_MASK) | ADDR_W'({cnt_q, 2'b00});
        if (mem_ready) begin
          rdata = mem_rdata;
          if (state_q == I_BURST) begin
            i_rvalid = 1'b1;
            i_word   = cnt_q;
            i_done   = (cnt_q == LAST_BEAT);
          end else begin
            d_rvalid = 1'b1;
            d_word   = cnt_q;
            d_done   = (cnt_q == LAST_BEAT);
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = 2'd0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      D_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q & WORD_MASK;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          d_done  = 1'b1;
          state_d = GAP;
        end
      end

      GAP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational from the request, so hold them low while reset is asserted
  assign i_grant = grant_i & rst_n;
  assign d_grant = grant_d & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      last_side_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_side_q <= last_side_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized requesters,
// every output compared each cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_grant, i_rvalid, i_done;
  logic [1:0]  i_word;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_grant, d_rvalid, d_done;
  logic [1:0]  d_word;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int total = 0;
  int bad = 0;

  // Stimulus knobs
  bit rnd_req = 0, rnd_data = 0, rnd_ready = 0;
  bit want_i = 0, want_d = 0;
  bit ready_q[$];
  bit i_drop = 0, d_drop = 0;

  // Reference model: owner 0 = none, 1 = I, 2 = D
  int          m_owner = 0;
  bit          m_write = 0;
  int          m_beats = 0;
  bit          m_gap = 0;
  bit          m_last_d = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_grant   (i_grant),
    .i_rvalid  (i_rvalid),
    .i_word    (i_word),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_grant   (d_grant),
    .d_rvalid  (d_rvalid),
    .d_word    (d_word),
    .d_done    (d_done),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Requesters hold req until their done, drop it the cycle after, and may re-raise from then on
  task automatic applyStimulus();
    if (rnd_data) begin
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
    end
    mem_rdata = $urandom;
    if (ready_q.size() > 0) mem_ready = ready_q.pop_front();
    else if (rnd_ready)     mem_ready = ($urandom_range(0, 3) != 0);
    else                    mem_ready = 1'b1;
    if (i_drop) begin
      i_req  = 1'b0;
      i_drop = 0;
    end else if (!i_req) begin
      i_req = rnd_req ? ($urandom_range(0, 3) == 0) : want_i;
    end
    if (d_drop) begin
      d_req  = 1'b0;
      d_drop = 0;
    end else if (!d_req) begin
      d_req = rnd_req ? ($urandom_range(0, 3) == 0) : want_d;
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic stepCycle();
    logic        e_ig, e_dg, e_irv, e_drv, e_idone, e_ddone, e_mreq, e_mwe;
    logic [1:0]  e_iw, e_dw;
    logic [31:0] e_rdata, e_maddr, e_mwdata;
    applyStimulus();
    #1;
    {e_ig, e_dg, e_irv, e_drv, e_idone, e_ddone, e_mreq, e_mwe} = '0;
    e_iw = 0; e_dw = 0; e_rdata = 0; e_maddr = 0; e_mwdata = 0;

    if (rst_n && !m_gap) begin
      if (m_owner == 0) begin
        if (i_req && d_req) begin
          e_ig = m_last_d;
          e_dg = !m_last_d;
        end else begin
          e_ig = i_req;
          e_dg = d_req;
        end
      end else if (m_write) begin
        e_mreq   = 1;
        e_mwe    = 1;
        e_maddr  = m_addr & 32'hFFFF_FFFC;
        e_mwdata = m_wdata;
        e_ddone  = mem_ready;
      end else begin
        e_mreq  = 1;
        e_maddr = (m_addr & 32'hFFFF_FFF0) + 32'(m_beats * 4);
        if (mem_ready) begin
          e_rdata = mem_rdata;
          if (m_owner == 1) begin
            e_irv = 1; e_iw = 2'(m_beats); e_idone = (m_beats == 3);
          end else begin
            e_drv = 1; e_dw = 2'(m_beats); e_ddone = (m_beats == 3);
          end
        end
      end
    end

    checkOutput("grant",     {30'd0, i_grant, d_grant},   {30'd0, e_ig, e_dg});
    checkOutput("rvalid",    {30'd0, i_rvalid, d_rvalid}, {30'd0, e_irv, e_drv});
    checkOutput("done",      {30'd0, i_done, d_done},     {30'd0, e_idone, e_ddone});
    checkOutput("i_word",    {30'd0, i_word},             {30'd0, e_iw});
    checkOutput("d_word",    {30'd0, d_word},             {30'd0, e_dw});
    checkOutput("rdata",     rdata,                       e_rdata);
    checkOutput("mem_ctl",   {30'd0, mem_req, mem_we},    {30'd0, e_mreq, e_mwe});
    checkOutput("mem_addr",  mem_addr,                    e_maddr);
    checkOutput("mem_wdata", mem_wdata,                   e_mwdata);

    if (!rst_n) begin
      m_owner = 0; m_gap = 0; m_beats = 0; m_last_d = 0; m_write = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_owner == 0) begin
      if (e_ig) begin
        m_owner = 1; m_last_d = 0; m_addr = i_addr; m_write = 0; m_beats = 0;
      end else if (e_dg) begin
        m_owner = 2; m_last_d = 1; m_addr = d_addr; m_write = d_we;
        m_wdata = d_wdata; m_beats = 0;
      end
    end else if (mem_ready) begin
      if (m_write || m_beats == 3) begin
        m_owner = 0; m_gap = 1; m_beats = 0;
      end else begin
        m_beats++;
      end
    end
    if (e_idone) i_drop = 1;
    if (e_ddone) d_drop = 1;
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);

    // Reset held with both requesters asserting, then continuous contention
    want_i = 1; want_d = 1;
    i_addr = 32'h0000_1234; d_addr = 32'h0000_5008; d_we = 0;
    repeat (3) stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("first_tie_is_d", {31'd0, m_owner == 2}, 32'd1);
    repeat (30) stepCycle();
    want_i = 0; want_d = 0;
    repeat (14) stepCycle();

    // D refill with back-pressure on two beats
    d_addr = 32'h0000_3000; d_we = 0; want_d = 1;
    ready_q = '{1, 1, 0, 1, 0, 1, 1};
    stepCycle();
    want_d = 0;
    repeat (10) stepCycle();

    // D single-word write with delayed ready
    d_addr = 32'h0000_2007; d_wdata = 32'hDEAD_BEEF; d_we = 1; want_d = 1;
    ready_q = '{1, 0, 0, 1};
    stepCycle();
    want_d = 0;
    repeat (6) stepCycle();

    // Reset in the middle of an I refill, then a fresh grant restarting at word 0
    i_addr = 32'h0000_4440; want_i = 1;
    repeat (4) stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    want_i = 0;
    repeat (10) stepCycle();

    // Randomized requesters, data and ready, with occasional resets
    rnd_req = 1; rnd_data = 1; rnd_ready = 1;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
